// File: rtl/clk_divider_prog.sv
// clk_divider_prog
//   Runtime-programmable integer clock divider. It produces a registered,
//   glitch-free divided clock from clk_i. The divisor is changed through a
//   load/ack handshake, and a new divisor only takes effect at a period
//   boundary.
//
//   Optional feature: define CLKDIV_TICK_EN to add tick_o. tick_o is a
//   one-cycle strobe in the cycle after each period boundary.
//
// Ports
//   clk_i       core clock
//   rst_i       synchronous active-high reset
//   en_i        count enable; low freezes the counter and clk_o
//   div_i       requested divisor (values 0 and 1 are clamped to 2)
//   div_load_i  strobe that captures div_i as the pending divisor
//   div_ack_o   one-cycle pulse when the pending divisor takes effect
//   div_o       divisor currently in force
//   clk_o       divided clock: low for ceil(N/2) counts, high for floor(N/2)
//   tick_o      end-of-period strobe (only with CLKDIV_TICK_EN)
module clk_divider_prog #(
    parameter int CNT_W     = 16,
    parameter int DIV_RESET = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] div_i,
    input  logic             div_load_i,
    output logic             div_ack_o,
    output logic [CNT_W-1:0] div_o,
`ifdef CLKDIV_TICK_EN
    output logic             tick_o,
`endif
    output logic             clk_o
);

    localparam logic [CNT_W-1:0] DIV_RST_C =
        (DIV_RESET < 2) ? CNT_W'(2) : CNT_W'(DIV_RESET);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_q, clk_d;
    logic             ack_q, ack_d;
    logic             boundary, apply;
    logic [CNT_W-1:0] div_in_clamped;
    logic [CNT_W:0]   half;

    assign div_in_clamped = (div_i < CNT_W'(2)) ? CNT_W'(2) : div_i;
    assign boundary       = en_i && (cnt_q == div_q - CNT_W'(1));
    // A load landing on a boundary edge must wait for the next boundary.
    // Because of this, the newest pending value is the only one ever applied.
    assign apply          = boundary && pend_vld_q && !div_load_i;

    always_comb begin
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        ack_d      = 1'b0;

        if (boundary) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (apply) begin
            div_d      = pend_q;
            pend_vld_d = 1'b0;
            ack_d      = 1'b1;
        end

        if (div_load_i) begin
            pend_d     = div_in_clamped;
            pend_vld_d = 1'b1;
        end

        // clk_o is registered from the next count and divisor, so it moves on
        // the same edge as cnt. half is one bit wider so that N = 2^CNT_W-1
        // cannot overflow.
        half  = ({1'b0, div_d} + (CNT_W+1)'(1)) >> 1;
        clk_d = ({1'b0, cnt_d} >= half);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            div_q      <= DIV_RST_C;
            pend_q     <= DIV_RST_C;
            pend_vld_q <= 1'b0;
            clk_q      <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            clk_q      <= clk_d;
            ack_q      <= ack_d;
        end
    end

`ifdef CLKDIV_TICK_EN
    logic tick_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) tick_q <= 1'b0;
        else       tick_q <= boundary;
    end
    assign tick_o = tick_q;
`endif

    assign div_ack_o = ack_q;
    assign div_o     = div_q;
    assign clk_o     = clk_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Scoreboard bench for clk_divider_prog. Each stimulus step pushes the
// hand-computed outputs expected after that clock edge. A monitor on the
// falling edge pops those expectations and compares them with the DUT.
module tb_clk_divider_prog;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst, en, ld;
    logic [CNT_W-1:0] div_in;
    logic             ack, clk_div;
    logic [CNT_W-1:0] div_out;
`ifdef CLKDIV_TICK_EN
    logic             tick;
`endif

    typedef struct {
        logic             c;
        logic [CNT_W-1:0] d;
        logic             a;
        logic             t;
        int               id;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   step_id = 0;
    bit   done = 0;

    clk_divider_prog #(.CNT_W(CNT_W), .DIV_RESET(2)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .div_i      (div_in),
        .div_load_i (ld),
        .div_ack_o  (ack),
        .div_o      (div_out),
`ifdef CLKDIV_TICK_EN
        .tick_o     (tick),
`endif
        .clk_o      (clk_div)
    );

    always #5 clk = ~clk;

    // Monitor: the DUT presents its outputs every cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_chk++;
            if (clk_div !== e.c) begin
                n_fail++;
                $display("FAIL clk_o step %0d: got %b want %b", e.id, clk_div, e.c);
            end
            n_chk++;
            if (div_out !== e.d) begin
                n_fail++;
                $display("FAIL div_o step %0d: got %0d want %0d", e.id, div_out, e.d);
            end
            n_chk++;
            if (ack !== e.a) begin
                n_fail++;
                $display("FAIL div_ack_o step %0d: got %b want %b", e.id, ack, e.a);
            end
`ifdef CLKDIV_TICK_EN
            n_chk++;
            if (tick !== e.t) begin
                n_fail++;
                $display("FAIL tick_o step %0d: got %b want %b", e.id, tick, e.t);
            end
`endif
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after its edge.
    task automatic step(input logic r, input logic e, input logic l,
                        input int dv, input logic xc, input int xd,
                        input logic xa, input logic xt);
        exp_t x;
        rst = r; en = e; ld = l; div_in = CNT_W'(dv);
        @(posedge clk);
        x.c = xc; x.d = CNT_W'(xd); x.a = xa; x.t = xt; x.id = step_id;
        exp_q.push_back(x);
        step_id++;
        @(negedge clk);
    endtask

    // Plain counting step with no load.
    task automatic run(input logic xc, input int xd, input logic xt);
        step(0, 1, 0, 0, xc, xd, 0, xt);
    endtask

    initial begin
        rst = 1; en = 0; ld = 0; div_in = '0;
        @(negedge clk);

        // 1: reset, then N=2 toggles every cycle
        step(1, 0, 0, 0, 0, 2, 0, 0);
        for (int i = 0; i < 4; i++) begin
            run(1, 2, 0);
            run(0, 2, 1);
        end

        // 2: load 5 while N=2, then low 3 / high 2
        step(0, 1, 1, 5, 1, 2, 0, 0);
        step(0, 1, 0, 0, 0, 5, 1, 1);
        for (int i = 0; i < 2; i++) begin
            run(0, 5, 0); run(0, 5, 0); run(1, 5, 0); run(1, 5, 0); run(0, 5, 1);
        end

        // 3: move to N=10, then load 7 and 4 inside one period -> single ack, N=4
        step(0, 1, 1, 10, 0, 5, 0, 0);
        run(0, 5, 0); run(1, 5, 0); run(1, 5, 0);
        step(0, 1, 0, 0, 0, 10, 1, 1);
        step(0, 1, 1, 7, 0, 10, 0, 0);
        run(0, 10, 0);
        step(0, 1, 1, 4, 0, 10, 0, 0);
        run(0, 10, 0);
        for (int i = 0; i < 5; i++) run(1, 10, 0);
        step(0, 1, 0, 0, 0, 4, 1, 1);
        for (int i = 0; i < 2; i++) begin
            run(0, 4, 0); run(1, 4, 0); run(1, 4, 0); run(0, 4, 1);
        end

        // 4: load 0 -> 2, then load 1 -> 2 (same value still acks)
        step(0, 1, 1, 0, 0, 4, 0, 0);
        run(1, 4, 0); run(1, 4, 0);
        step(0, 1, 0, 0, 0, 2, 1, 1);
        step(0, 1, 1, 1, 1, 2, 0, 0);
        step(0, 1, 0, 0, 0, 2, 1, 1);
        run(1, 2, 0); run(0, 2, 1);

        // 5: N=6 with en_i low for 3 cycles at cnt=2
        step(0, 1, 1, 6, 1, 2, 0, 0);
        step(0, 1, 0, 0, 0, 6, 1, 1);
        run(0, 6, 0); run(0, 6, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 6, 0, 0);
        run(1, 6, 0); run(1, 6, 0); run(1, 6, 0); run(0, 6, 1);

        // 6: N=9, pending load 3, reset at cnt=4 -> pending dropped, no ack
        step(0, 1, 1, 9, 0, 6, 0, 0);
        run(0, 6, 0); run(1, 6, 0); run(1, 6, 0); run(1, 6, 0);
        step(0, 1, 0, 0, 0, 9, 1, 1);
        step(0, 1, 1, 3, 0, 9, 0, 0);
        run(0, 9, 0); run(0, 9, 0); run(0, 9, 0);
        step(1, 1, 0, 0, 0, 2, 0, 0);
        for (int i = 0; i < 3; i++) begin
            run(1, 2, 0); run(0, 2, 1);
        end
        // reset wins over a simultaneous load
        step(1, 1, 1, 7, 0, 2, 0, 0);
        run(1, 2, 0); run(0, 2, 1); run(1, 2, 0);

        // 7: load on a boundary edge is applied at the following boundary
        step(0, 1, 1, 3, 0, 2, 0, 1);
        run(1, 2, 0);
        step(0, 1, 0, 0, 0, 3, 1, 1);
        run(0, 3, 0); run(1, 3, 0); run(0, 3, 1);

        en = 0; ld = 0; rst = 0;
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
